hdu_ram_wb_mux: RTL and testbench



---
 rtl/hdu_ram_wb_mux_pkg.sv | 23 ++
 rtl/hdu_ram_wb_mux_data_ram.sv | 25 ++
 rtl/hdu_ram_wb_mux.sv | 112 +++++++++++
 tb/tb_hdu_ram_wb_mux.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hdu_ram_wb_mux_pkg.sv
// Shared encodings for the memory/writeback slice: WB select codes and control-word bit positions.
// Latency: none (types and constants only). Backpressure: none.
package hdu_ram_wb_mux_pkg;

    typedef enum logic [1:0] {
        WB_ALU    = 2'b00,
        WB_MEM    = 2'b01,
        WB_OFFSET = 2'b10,
        WB_LINK   = 2'b11
    } wb_sel_e;

    localparam int unsigned CTRL_ALU_SRC_BIT       = 2;
    localparam int unsigned CTRL_MEM_TO_REG_BIT    = 3;
    localparam int unsigned CTRL_REG_WRITE_BIT     = 4;
    localparam int unsigned CTRL_MEM_READ_BIT      = 5;
    localparam int unsigned CTRL_MEM_WRITE_BIT     = 6;
    localparam int unsigned CTRL_OFFSET_TO_REG_BIT = 12;

    function automatic wb_sel_e wb_sel(input logic offset_to_reg, input logic mem_to_reg);
        return wb_sel_e'({offset_to_reg, mem_to_reg});
    endfunction

endpackage

// File: rtl/hdu_ram_wb_mux_data_ram.sv
// Word-addressed data RAM, 2^ADDR_WIDTH x DATA_WIDTH; async read of current contents, write on rising edge.
// Latency: read 0 cycles, write visible the cycle after its edge. Backpressure: none, always accepts.
module data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are deliberately never reset; a testbench may preload them.
    logic [DATA_WIDTH-1:0] MEM [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            MEM[addr] <= wdata;
        end
    end

    assign rdata = MEM[addr];

endmodule

// File: rtl/hdu_ram_wb_mux.sv
// Load-use hazard detect, data RAM, MEM/WB register and writeback mux; HDU_X0_FILTER_EN stops x0 loads stalling.
// Latency: notStall combinational, dataD one edge after MEM inputs. Backpressure: none; notStall=0 asks upstream to stall.
module hdu_ram_wb_mux
    import hdu_ram_wb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  EX_MemRead,
    input  logic [4:0]            EX_Rd,
    input  logic [4:0]            ID_Rs1,
    input  logic [4:0]            ID_Rs2,
    output logic                  notStall,
    input  logic                  MEM_MemWrite,
    input  logic [DATA_WIDTH-1:0] MEM_aluResult,
    input  logic [DATA_WIDTH-1:0] MEM_dataB,
    input  logic                  MEM_RegWrite,
    input  logic                  MEM_MemToReg,
    input  logic                  MEM_OffsetToReg,
    input  logic [4:0]            MEM_Rd,
    input  logic [DATA_WIDTH-1:0] MEM_branchAddr,
    input  logic [DATA_WIDTH-1:0] MEM_next_imemAddr,
    output logic                  WB_RegWrite,
    output logic [4:0]            WB_Rd,
    output logic [DATA_WIDTH-1:0] dataD
);

    logic                  load_use_hit;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  reg_write_d,     reg_write_q;
    logic                  mem_to_reg_d,    mem_to_reg_q;
    logic                  offset_to_reg_d, offset_to_reg_q;
    logic [4:0]            rd_d,            rd_q;
    logic [DATA_WIDTH-1:0] alu_result_d,    alu_result_q;
    logic [DATA_WIDTH-1:0] mem_data_d,      mem_data_q;
    logic [DATA_WIDTH-1:0] branch_addr_d,   branch_addr_q;
    logic [DATA_WIDTH-1:0] next_addr_d,     next_addr_q;

    // Hazard detection ignores clear: it only looks at the ID/EX operands this cycle.
    always_comb begin
        load_use_hit = EX_MemRead & ((EX_Rd == ID_Rs1) | (EX_Rd == ID_Rs2));
`ifdef HDU_X0_FILTER_EN
        load_use_hit = load_use_hit & (EX_Rd != 5'd0);
`endif
        notStall = ~load_use_hit;
    end

    assign ram_we = MEM_MemWrite & ~clear;

    data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_data_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (MEM_aluResult[ADDR_WIDTH-1:0]),
        .wdata (MEM_dataB),
        .rdata (ram_rdata)
    );

    always_comb begin
        reg_write_d     = MEM_RegWrite;
        mem_to_reg_d    = MEM_MemToReg;
        offset_to_reg_d = MEM_OffsetToReg;
        rd_d            = MEM_Rd;
        alu_result_d    = MEM_aluResult;
        mem_data_d      = ram_rdata;
        branch_addr_d   = MEM_branchAddr;
        next_addr_d     = MEM_next_imemAddr;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            offset_to_reg_q <= 1'b0;
            rd_q            <= '0;
            alu_result_q    <= '0;
            mem_data_q      <= '0;
            branch_addr_q   <= '0;
            next_addr_q     <= '0;
        end else begin
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            offset_to_reg_q <= offset_to_reg_d;
            rd_q            <= rd_d;
            alu_result_q    <= alu_result_d;
            mem_data_q      <= mem_data_d;
            branch_addr_q   <= branch_addr_d;
            next_addr_q     <= next_addr_d;
        end
    end

    always_comb begin
        dataD = alu_result_q;
        unique case (wb_sel(offset_to_reg_q, mem_to_reg_q))
            WB_ALU:    dataD = alu_result_q;
            WB_MEM:    dataD = mem_data_q;
            WB_OFFSET: dataD = branch_addr_q;
            WB_LINK:   dataD = next_addr_q;
            default:   dataD = alu_result_q;
        endcase
    end

    assign WB_RegWrite = reg_write_q;
    assign WB_Rd       = rd_q;

endmodule

// File: tb/tb_hdu_ram_wb_mux.sv
// Directed bench for hdu_ram_wb_mux: HDU vectors, store/load, wrap, WB mux select and clear behaviour.
module tb_hdu_ram_wb_mux;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          clear;
    logic          EX_MemRead;
    logic [4:0]    EX_Rd, ID_Rs1, ID_Rs2;
    logic          notStall;
    logic          MEM_MemWrite;
    logic [DW-1:0] MEM_aluResult, MEM_dataB;
    logic          MEM_RegWrite, MEM_MemToReg, MEM_OffsetToReg;
    logic [4:0]    MEM_Rd;
    logic [DW-1:0] MEM_branchAddr, MEM_next_imemAddr;
    logic          WB_RegWrite;
    logic [4:0]    WB_Rd;
    logic [DW-1:0] dataD;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    hdu_ram_wb_mux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock             (clock),
        .clear             (clear),
        .EX_MemRead        (EX_MemRead),
        .EX_Rd             (EX_Rd),
        .ID_Rs1            (ID_Rs1),
        .ID_Rs2            (ID_Rs2),
        .notStall          (notStall),
        .MEM_MemWrite      (MEM_MemWrite),
        .MEM_aluResult     (MEM_aluResult),
        .MEM_dataB         (MEM_dataB),
        .MEM_RegWrite      (MEM_RegWrite),
        .MEM_MemToReg      (MEM_MemToReg),
        .MEM_OffsetToReg   (MEM_OffsetToReg),
        .MEM_Rd            (MEM_Rd),
        .MEM_branchAddr    (MEM_branchAddr),
        .MEM_next_imemAddr (MEM_next_imemAddr),
        .WB_RegWrite       (WB_RegWrite),
        .WB_Rd             (WB_Rd),
        .dataD             (dataD)
    );

    task automatic check(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_in(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdat,
                          input logic rw, input logic m2r, input logic o2r, input logic [4:0] rd);
        MEM_MemWrite    = we;
        MEM_aluResult   = addr;
        MEM_dataB       = wdat;
        MEM_RegWrite    = rw;
        MEM_MemToReg    = m2r;
        MEM_OffsetToReg = o2r;
        MEM_Rd          = rd;
    endtask

    task automatic hdu(input string tag, input logic rd_ld, input logic [4:0] ex_rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic exp_ns);
        EX_MemRead = rd_ld;
        EX_Rd      = ex_rd;
        ID_Rs1     = rs1;
        ID_Rs2     = rs2;
        #1;
        check(tag, {31'd0, notStall}, {31'd0, exp_ns});
    endtask

    logic x0_exp;

    initial begin
        clear             = 1'b1;
        EX_MemRead        = 1'b0;
        EX_Rd             = '0;
        ID_Rs1            = '0;
        ID_Rs2            = '0;
        MEM_branchAddr    = '0;
        MEM_next_imemAddr = '0;
        mem_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        check("rst_regwrite", {31'd0, WB_RegWrite}, 32'd0);
        check("rst_rd", {27'd0, WB_Rd}, 32'd0);
        check("rst_dataD", dataD, 32'd0);
        clear = 1'b0;

        hdu("hdu_rs1_hit", 1'b1, 5'd5, 5'd5, 5'd7, 1'b0);
        hdu("hdu_no_load", 1'b0, 5'd5, 5'd5, 5'd7, 1'b1);
        hdu("hdu_rs2_hit", 1'b1, 5'd9, 5'd3, 5'd9, 1'b0);
        hdu("hdu_miss", 1'b1, 5'd9, 5'd3, 5'd4, 1'b1);
`ifdef HDU_X0_FILTER_EN
        x0_exp = 1'b1;
`else
        x0_exp = 1'b0;
`endif
        hdu("hdu_x0", 1'b1, 5'd0, 5'd4, 5'd0, x0_exp);
        hdu("hdu_idle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);

        // Store 0xAB at 0x10, then load it into x3.
        mem_in(1'b1, 32'h10, 32'hAB, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 5'd3);
        tick();
        check("ld_dataD", dataD, 32'hAB);
        check("ld_rd", {27'd0, WB_Rd}, 32'd3);
        check("ld_regwrite", {31'd0, WB_RegWrite}, 32'd1);

        // Read in the write cycle returns the old word; new word the cycle after.
        mem_in(1'b1, 32'h10, 32'hCD, 1'b1, 1'b1, 1'b0, 5'd4);
        tick();
        check("rdw_old", dataD, 32'hAB);
        check("rdw_rd", {27'd0, WB_Rd}, 32'd4);
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 5'd4);
        tick();
        check("rdw_new", dataD, 32'hCD);

        // Address wrap: 0x1FF lands in word 255.
        mem_in(1'b1, 32'h1FF, 32'h41, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        mem_in(1'b0, 32'hFF, 32'h0, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        check("wrap_ff", dataD, 32'h41);
        mem_in(1'b0, 32'h2FF, 32'h0, 1'b1, 1'b1, 1'b0, 5'd6);
        tick();
        check("wrap_2ff", dataD, 32'h41);

        // Writeback select.
        MEM_branchAddr    = 32'h20;
        MEM_next_imemAddr = 32'h30;
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 5'd8);
        tick();
        check("wb_alu", dataD, 32'h10);
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
        tick();
        check("wb_offset", dataD, 32'h20);
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 5'd8);
        tick();
        check("wb_link", dataD, 32'h30);
        mem_in(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8);
        tick();
        check("wb_mem", dataD, 32'hCD);

        // Clear blocks a simultaneous store and flushes MEM/WB.
        mem_in(1'b1, 32'h4, 32'h11, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        clear = 1'b1;
        mem_in(1'b1, 32'h4, 32'h55, 1'b1, 1'b1, 1'b0, 5'd7);
        hdu("hdu_during_clear", 1'b1, 5'd5, 5'd5, 5'd1, 1'b0);
        tick();
        check("clr_regwrite", {31'd0, WB_RegWrite}, 32'd0);
        check("clr_rd", {27'd0, WB_Rd}, 32'd0);
        check("clr_dataD", dataD, 32'd0);
        clear = 1'b0;
        mem_in(1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 1'b0, 5'd7);
        tick();
        check("post_clr_mem4", dataD, 32'h11);
        check("post_clr_rd", {27'd0, WB_Rd}, 32'd7);
        check("post_clr_regwrite", {31'd0, WB_RegWrite}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
